// File: rtl/audio_capture.sv
// Codec ADC drain, L/R mono mix and triggered capture into RAM; optional peak meter via AUDIO_CAPTURE_PEAK_EN.
// Latency: sample written and rec_count updated one edge after the read pulse starts; play_data is 1-cycle registered.
// Backpressure: none; codec popped at most once per 3 cycles, samples always drained even when not recording.
module audio_capture #(
    parameter int DEPTH_LOG2 = 15,
    parameter int WIDTH      = 24
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  read_ready,
    input  logic [WIDTH-1:0]      readdata_left,
    input  logic [WIDTH-1:0]      readdata_right,
    output logic                  read,
    input  logic                  rec_start,
    input  logic                  rec_abort,
    input  logic [DEPTH_LOG2-1:0] play_addr,
    output logic [WIDTH-1:0]      play_data,
    output logic                  recording,
    output logic                  rec_done,
    output logic [DEPTH_LOG2:0]   rec_count,
    output logic [WIDTH-1:0]      peak
);

    typedef enum logic [1:0] {S_IDLE, S_RECORD, S_DONE} state_t;

    state_t                   r_state;
    logic                     r_start_q;
    logic [1:0]               r_hold;
    logic                     r_read;
    logic signed [WIDTH-1:0]  r_mono;
    logic [DEPTH_LOG2:0]      r_count;
    logic                     r_recording;
    logic                     r_done;
    logic [WIDTH-1:0]         r_play;
    logic [WIDTH-1:0]         r_mem [0:(1<<DEPTH_LOG2)-1];

    logic signed [WIDTH-1:0]  w_mono;
    logic                     w_capture;
    logic                     w_start_edge;
    logic                     w_start_go;
    logic                     w_we;
    logic                     w_last;

    // Halving each channel before the add keeps the sum inside WIDTH bits.
    assign w_mono       = ($signed(readdata_left) >>> 1) + ($signed(readdata_right) >>> 1);
    assign w_capture    = read_ready && (r_hold == 2'd0);
    assign w_start_edge = rec_start && !r_start_q;
    assign w_start_go   = (r_state != S_RECORD) && w_start_edge && !rec_abort;
    assign w_we         = (r_state == S_RECORD) && r_read && !rec_abort;
    assign w_last       = &r_count[DEPTH_LOG2-1:0];

    // r_hold masks read_ready for the two edges the codec needs to refresh its flag.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_read <= 1'b0;
            r_hold <= 2'd0;
            r_mono <= '0;
        end else if (w_capture) begin
            r_mono <= w_mono;
            r_read <= 1'b1;
            r_hold <= 2'd2;
        end else begin
            r_read <= 1'b0;
            if (r_hold != 2'd0) begin
                r_hold <= r_hold - 2'd1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_start_q   <= 1'b0;
            r_count     <= '0;
            r_recording <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_start_q <= rec_start;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_edge && rec_abort) begin
                        r_state     <= S_DONE;
                        r_recording <= 1'b0;
                        r_done      <= 1'b1;
                    end else if (w_start_go) begin
                        r_state     <= S_RECORD;
                        r_recording <= 1'b1;
                        r_done      <= 1'b0;
                        r_count     <= '0;
                    end
                end
                S_RECORD: begin
                    if (rec_abort) begin
                        r_state     <= S_DONE;
                        r_recording <= 1'b0;
                        r_done      <= 1'b1;
                    end else if (r_read) begin
                        r_count <= r_count + 1'b1;
                        if (w_last) begin
                            r_state     <= S_DONE;
                            r_recording <= 1'b0;
                            r_done      <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_recording <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (w_we) begin
            r_mem[r_count[DEPTH_LOG2-1:0]] <= r_mono;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_play <= '0;
        end else begin
            r_play <= r_mem[play_addr];
        end
    end

`ifdef AUDIO_CAPTURE_PEAK_EN
    logic [WIDTH-1:0] r_peak;
    logic [WIDTH-1:0] w_abs;

    // The most negative sample has no positive twin, so it clamps to full scale.
    always_comb begin
        w_abs = r_mono;
        if (r_mono[WIDTH-1]) begin
            if (r_mono == {1'b1, {(WIDTH-1){1'b0}}}) begin
                w_abs = {1'b0, {(WIDTH-1){1'b1}}};
            end else begin
                w_abs = WIDTH'(-r_mono);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_peak <= '0;
        end else if (w_start_go) begin
            r_peak <= '0;
        end else if (w_we && (w_abs > r_peak)) begin
            r_peak <= w_abs;
        end
    end

    assign peak = r_peak;
`else
    assign peak = '0;
`endif

    assign read      = r_read;
    assign play_data = r_play;
    assign recording = r_recording;
    assign rec_done  = r_done;
    assign rec_count = r_count;

endmodule

// File: tb/tb_audio_capture.sv
// Randomized scoreboard bench for audio_capture: codec model feeds samples, a monitor checks each read pulse's effects.
module tb_audio_capture;

    localparam int DL    = 4;
    localparam int W     = 24;
    localparam int DEPTH = 16;

    logic          CLOCK_50 = 1'b0;
    logic          reset;
    logic          read_ready;
    logic [W-1:0]  readdata_left;
    logic [W-1:0]  readdata_right;
    logic          read;
    logic          rec_start;
    logic          rec_abort;
    logic [DL-1:0] play_addr;
    logic [W-1:0]  play_data;
    logic          recording;
    logic          rec_done;
    logic [DL:0]   rec_count;
    logic [W-1:0]  peak;

    always #5 CLOCK_50 = ~CLOCK_50;

    audio_capture #(.DEPTH_LOG2(DL), .WIDTH(W)) dut (
        .CLOCK_50       (CLOCK_50),
        .reset          (reset),
        .read_ready     (read_ready),
        .readdata_left  (readdata_left),
        .readdata_right (readdata_right),
        .read           (read),
        .rec_start      (rec_start),
        .rec_abort      (rec_abort),
        .play_addr      (play_addr),
        .play_data      (play_data),
        .recording      (recording),
        .rec_done       (rec_done),
        .rec_count      (rec_count),
        .peak           (peak)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int half_floor(input int v);
        if (v < 0 && (v % 2) != 0) return v / 2 - 1;
        return v / 2;
    endfunction

    function automatic logic [W-1:0] mono_of(input logic [W-1:0] l, input logic [W-1:0] r);
        int li;
        int ri;
        li = int'($signed(l));
        ri = int'($signed(r));
        return W'(half_floor(li) + half_floor(ri));
    endfunction

    function automatic logic [W-1:0] abs_sat(input logic [W-1:0] m);
        int v;
        v = int'($signed(m));
        if (v < 0) v = -v;
        if (v > 8388607) v = 8388607;
        return W'(v);
    endfunction

    logic [W-1:0] model_ram [DEPTH];
    bit           model_vld [DEPTH];
    bit           m_rec  = 0;
    bit           m_done = 0;
    int           m_cnt  = 0;
    logic [W-1:0] m_peak = '0;

    function automatic logic [W-1:0] exp_peak();
`ifdef AUDIO_CAPTURE_PEAK_EN
        return m_peak;
`else
        return '0;
`endif
    endfunction

    // ---------------- codec model ----------------
    logic [W-1:0] ql[$];
    logic [W-1:0] qr[$];
    logic [W-1:0] exp_q[$];

    task automatic codec_update();
        read_ready = (ql.size() != 0);
        if (ql.size() != 0) begin
            readdata_left  = ql[0];
            readdata_right = qr[0];
        end
    endtask

    task automatic push_sample(input logic [W-1:0] l, input logic [W-1:0] r);
        ql.push_back(l);
        qr.push_back(r);
        exp_q.push_back(mono_of(l, r));
        codec_update();
    endtask

    always begin
        @(negedge CLOCK_50);
        if (read === 1'b1 && ql.size() != 0) begin
            void'(ql.pop_front());
            void'(qr.pop_front());
            codec_update();
        end
    end

    // ---------------- monitor / scoreboard ----------------
    bit mon_en     = 0;
    int cyc        = 0;
    int last_pulse = -100;
    int n_pulses   = 0;

    always @(posedge CLOCK_50) cyc++;

    always begin
        logic [W-1:0] m;
        bit           wr;
        @(negedge CLOCK_50);
        if (mon_en && read === 1'b1) begin
            n_pulses++;
            check("read_gap_ge3", (cyc - last_pulse) >= 3, 1);
            last_pulse = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_read_pulse", 1, 0);
            end else begin
                m  = exp_q.pop_front();
                wr = m_rec && !rec_abort;
                if (wr) begin
                    model_ram[m_cnt] = m;
                    model_vld[m_cnt] = 1;
                    play_addr        = DL'(m_cnt);
                    m_cnt++;
                    if (abs_sat(m) > m_peak) m_peak = abs_sat(m);
                    if (m_cnt == DEPTH) begin
                        m_rec  = 0;
                        m_done = 1;
                    end
                end else if (m_rec && rec_abort) begin
                    m_rec  = 0;
                    m_done = 1;
                end
                @(posedge CLOCK_50);
                #1;
                check("read_width_1", read, 0);
                check("mon_rec_count", rec_count, m_cnt);
                check("mon_recording", recording, m_rec);
                check("mon_rec_done", rec_done, m_done);
                check("mon_peak", peak, exp_peak());
                if (wr) begin
                    @(posedge CLOCK_50);
                    #1;
                    check("mon_play_data", play_data, m);
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_drain();
        int t;
        t = 0;
        while ((ql.size() != 0 || exp_q.size() != 0) && t < 2000) begin
            @(posedge CLOCK_50);
            t++;
        end
        check("drain_done", (ql.size() == 0 && exp_q.size() == 0), 1);
        repeat (4) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
    endtask

    task automatic do_start();
        @(negedge CLOCK_50);
        rec_start = 1'b1;
        @(posedge CLOCK_50);
        m_rec  = 1;
        m_done = 0;
        m_cnt  = 0;
        m_peak = '0;
        #1;
        check("start_recording", recording, 1);
        check("start_rec_done", rec_done, 0);
        check("start_rec_count", rec_count, 0);
        check("start_peak", peak, 0);
        @(negedge CLOCK_50);
        rec_start = 1'b0;
    endtask

    task automatic scan_ram();
        for (int k = 0; k < DEPTH; k++) begin
            if (model_vld[k]) begin
                @(negedge CLOCK_50);
                play_addr = DL'(k);
                @(posedge CLOCK_50);
                #1;
                check("ram_scan", play_data, model_ram[k]);
            end
        end
        @(negedge CLOCK_50);
    endtask

    task automatic push_random(input int n, input int max_gap);
        for (int i = 0; i < n; i++) begin
            push_sample(W'($urandom), W'($urandom));
            repeat ($urandom_range(0, max_gap)) @(negedge CLOCK_50);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

    // ---------------- main stimulus ----------------
    initial begin
        int c0;
        reset          = 1'b1;
        read_ready     = 1'b0;
        readdata_left  = '0;
        readdata_right = '0;
        rec_start      = 1'b0;
        rec_abort      = 1'b0;
        play_addr      = '0;
        for (int k = 0; k < DEPTH; k++) model_vld[k] = 0;

        repeat (3) @(posedge CLOCK_50);
        #1;
        check("rst_read", read, 0);
        check("rst_play_data", play_data, 0);
        check("rst_recording", recording, 0);
        check("rst_rec_done", rec_done, 0);
        check("rst_rec_count", rec_count, 0);
        check("rst_peak", peak, 0);
        @(negedge CLOCK_50);
        reset = 1'b0;

        // Reset asserted while the read pulse is high
        push_sample(W'($urandom), W'($urandom));
        for (int i = 0; i < 20; i++) begin
            @(posedge CLOCK_50);
            #1;
            if (read) break;
        end
        check("hs_read_seen", read, 1);
        reset = 1'b1;
        #1;
        check("hs_rst_read", read, 0);
        check("hs_rst_recording", recording, 0);
        check("hs_rst_rec_done", rec_done, 0);
        check("hs_rst_rec_count", rec_count, 0);
        check("hs_rst_play_data", play_data, 0);
        @(negedge CLOCK_50);
        reset = 1'b0;
        ql.delete();
        qr.delete();
        exp_q.delete();
        codec_update();
        repeat (3) @(negedge CLOCK_50);
        mon_en = 1;

        // IDLE drain with read_ready held high
        for (int i = 0; i < 20; i++) push_sample(W'($urandom), W'($urandom));
        c0 = n_pulses;
        repeat (30) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("idle_pulses_in_30", n_pulses - c0, 10);
        check("idle_rec_count", rec_count, 0);
        wait_drain();

        // Full recording of a ramp, extra samples discarded
        do_start();
        for (int k = 0; k < 20; k++) begin
            if (k < DEPTH) push_sample(W'(k * 256), W'(k * 256));
            else push_sample(W'($urandom), W'($urandom));
        end
        wait_drain();
        check("full_rec_done", rec_done, 1);
        check("full_recording", recording, 0);
        check("full_rec_count", rec_count, 16);
        scan_ram();

        // Abort with a sixth sample in flight
        do_start();
        push_random(5, 3);
        wait_drain();
        check("abort_pre_count", rec_count, 5);
        push_sample(W'($urandom), W'($urandom));
        for (int i = 0; i < 20; i++) begin
            @(posedge CLOCK_50);
            #1;
            if (read) break;
        end
        rec_abort = 1'b1;
        @(posedge CLOCK_50);
        #1;
        check("abort_rec_count", rec_count, 5);
        check("abort_rec_done", rec_done, 1);
        @(negedge CLOCK_50);
        rec_abort = 1'b0;
        wait_drain();
        scan_ram();

        // Full-scale extremes and peak meter
        do_start();
        push_sample(24'h7FFFFF, 24'h7FFFFF);
        push_sample(24'h800000, 24'h800000);
        push_random(25, 4);
        wait_drain();
        check("ext_peak_final", peak, exp_peak());
        scan_ram();

        // start edge together with abort from DONE
        @(negedge CLOCK_50);
        rec_start = 1'b1;
        rec_abort = 1'b1;
        @(posedge CLOCK_50);
        #1;
        check("sa_rec_done", rec_done, 1);
        check("sa_recording", recording, 0);
        check("sa_rec_count", rec_count, m_cnt);
        @(negedge CLOCK_50);
        rec_start = 1'b0;
        rec_abort = 1'b0;
        @(negedge CLOCK_50);
        do_start();
        push_random(25, 4);
        wait_drain();
        scan_ram();

        // Reset in the middle of a recording
        do_start();
        push_random(3, 2);
        wait_drain();
        check("mid_pre_count", rec_count, 3);
        reset = 1'b1;
        #1;
        m_rec  = 0;
        m_done = 0;
        m_cnt  = 0;
        m_peak = '0;
        check("mid_rst_count", rec_count, 0);
        check("mid_rst_recording", recording, 0);
        check("mid_rst_peak", peak, 0);
        @(negedge CLOCK_50);
        reset = 1'b0;
        repeat (3) @(negedge CLOCK_50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
